inst_fetch_queue: RTL

Parametrised successor to the single instruction register: a DEPTH-entry first-word-fall-through queue of fetched instructions, each tagged with its PC. It sits between instruction memory/fetch and decode. It decouples fetch from decode stalls with valid/ready handshakes on both sides, and discards all buffered instructions on a branch/jump flush.

---
 rtl/inst_fetch_queue_if.sv | 30 +++
 rtl/inst_fetch_queue.sv | 100 ++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction fetch queue.
// master = the fetch/decode pair driving the queue, slave = the queue itself.
interface inst_fetch_queue_if #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
);
  localparam int AW = $clog2(DEPTH);

  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_inst;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_inst;
  logic [PC_WIDTH-1:0] out_pc;
  logic [AW:0]         count;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_inst, out_pc, count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// DEPTH-entry first-word-fall-through queue of {pc, inst} pairs between
// fetch and decode. Flush drops every buffered entry on a redirect.

// One storage slot. No reset: contents are only observed through valid.
module inst_fetch_queue_entry #(
  parameter int EW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [EW-1:0] d,
  output logic [EW-1:0] q
);
  // capture the incoming entry when this slot is the write target
  always_ff @(posedge clk) begin
    if (we) q <= d;
  end
endmodule

module inst_fetch_queue #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_fetch_queue_if.slave    q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [WIDTH-1:0]    inst;
  } fq_entry_t;

  localparam int EW = $bits(fq_entry_t);

  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        full, empty, push, pop, wr_en;
  fq_entry_t                   din, head;
  logic [DEPTH-1:0][EW-1:0]    ent_q;
  logic [DEPTH-1:0]            ent_we;

  // Ready/valid come only from registered occupancy, so a pop never opens
  // a slot for a push in the same cycle and there is no out_ready->in_ready path.
  assign full   = (count == FULL);
  assign empty  = (count == '0);
  assign push   = q.in_valid & ~full;
  assign pop    = ~empty & q.out_ready;
  // A flushed or reset cycle must not leave a stale write behind.
  assign wr_en  = push & rst & ~q.flush;

  assign din.pc   = q.in_pc;
  assign din.inst = q.in_inst;

  // one slot per entry; write enable decoded from wr_ptr
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign ent_we[i] = wr_en & (wr_ptr == AW'(i));
    inst_fetch_queue_entry #(.EW(EW)) u_ent (
      .clk (clk),
      .we  (ent_we[i]),
      .d   (din),
      .q   (ent_q[i])
    );
  end

  // pointer and occupancy bookkeeping; reset beats flush beats handshakes
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // head fall-through, forced to zero when nothing is buffered
  always_comb begin
    head = fq_entry_t'(ent_q[rd_ptr]);
    if (empty) head = '0;
  end

  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.out_inst  = head.inst;
  assign q.out_pc    = head.pc;
  assign q.count     = count;
endmodule
